// File: rtl/motor_pkg.sv
// Shared encodings for the two-motor H-bridge drive controller.
package motor_pkg;

   localparam logic [1:0] DIR_OFF = 2'b00;
   localparam logic [1:0] DIR_FWD = 2'b01;
   localparam logic [1:0] DIR_REV = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DEAD = 2'b10;

endpackage

// File: rtl/motor_channel.sv
// One bridge channel: duty ramping, IDLE/RUN/DEAD sequencing and the registered pin pair.
module motor_channel
   import motor_pkg::*;
#(
   parameter int unsigned PWM_W        = 8,
   parameter int unsigned RAMP_STEP    = 16,
   parameter int unsigned DEAD_PERIODS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pb,
   input  logic [PWM_W-1:0] cnt,
   input  logic [1:0]       cmd_dir,
   input  logic [PWM_W-1:0] target,
   output logic             pin_fwd,
   output logic             pin_rev,
   output logic [PWM_W-1:0] duty
);

   localparam int unsigned      DC_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS + 1) : 1;
   localparam logic [PWM_W-1:0] STEP = PWM_W'(RAMP_STEP);

   logic [1:0]       st_q;
   logic [1:0]       dir_q;
   logic [PWM_W-1:0] duty_q;
   logic [DC_W-1:0]  dead_q;
   logic [PWM_W-1:0] goal;
   logic [PWM_W-1:0] ramp_next;
   logic [PWM_W-1:0] first_step;
   logic             dead_last;

   // While the commanded direction disagrees with the running one, the ramp heads to zero.
   always_comb begin
      goal = (cmd_dir == dir_q) ? target : '0;
      if (duty_q < goal)
         ramp_next = ((goal - duty_q) > STEP) ? duty_q + STEP : goal;
      else
         ramp_next = ((duty_q - goal) > STEP) ? duty_q - STEP : goal;
      first_step = (target > STEP) ? STEP : target;
      dead_last  = (32'(dead_q) + 32'd1) >= DEAD_PERIODS;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= ST_IDLE;
         dir_q   <= DIR_OFF;
         duty_q  <= '0;
         dead_q  <= '0;
         pin_fwd <= 1'b0;
         pin_rev <= 1'b0;
      end else begin
         pin_fwd <= (st_q == ST_RUN) && (dir_q == DIR_FWD) && (cnt < duty_q);
         pin_rev <= (st_q == ST_RUN) && (dir_q == DIR_REV) && (cnt < duty_q);
         if (pb) begin
            case (st_q)
               ST_IDLE: begin
                  if ((cmd_dir != DIR_OFF) && (target != '0)) begin
                     st_q   <= ST_RUN;
                     dir_q  <= cmd_dir;
                     duty_q <= first_step;
                  end
               end
               ST_RUN: begin
                  duty_q <= ramp_next;
                  if ((cmd_dir != dir_q) && (ramp_next == '0)) begin
                     st_q   <= (cmd_dir == DIR_OFF) ? ST_IDLE : ST_DEAD;
                     dead_q <= '0;
                  end
               end
               ST_DEAD: begin
                  if (dead_last) begin
                     dead_q <= '0;
                     dir_q  <= cmd_dir;
                     if (cmd_dir == DIR_OFF) begin
                        st_q   <= ST_IDLE;
                        duty_q <= '0;
                     end else begin
                        st_q   <= ST_RUN;
                        duty_q <= first_step;
                     end
                  end else begin
                     dead_q <= dead_q + 1'b1;
                  end
               end
               default: st_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign duty = duty_q;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Two-motor H-bridge drive controller: prescaled PWM, command decode and speed presets.
module motor_drive_ctrl
   import motor_pkg::*;
#(
   parameter int unsigned PWM_W        = 8,
   parameter int unsigned PRESCALE     = 20,
   parameter int unsigned SPD_LO       = 160,
   parameter int unsigned SPD_MID      = 208,
   parameter int unsigned SPD_HI       = 240,
   parameter int unsigned RAMP_STEP    = 16,
   parameter int unsigned DEAD_PERIODS = 2
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic [1:0]       speed_sel,
   input  logic             StepEnable,
   input  logic             iS1,
   input  logic             iS2,
   input  logic             up,
   input  logic             down,
   input  logic             left,
   input  logic             right,
   output logic             IN1,
   output logic             IN2,
   output logic             IN3,
   output logic             IN4,
   output logic [PWM_W-1:0] duty_a,
   output logic [PWM_W-1:0] duty_b
);

   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0]  presc_q;
   logic [PWM_W-1:0] cnt_q;
   logic             tick;
   logic             pb;
   logic [PWM_W-1:0] preset;
   logic [1:0]       dir_a_d, dir_b_d, dir_a_q, dir_b_q;
   logic [PWM_W-1:0] tgt_a_q, tgt_b_q;

   assign tick = (32'(presc_q) == PRESCALE - 1);
   assign pb   = tick && (cnt_q == '1);

   always_ff @(posedge CLK) begin
      if (rst) begin
         presc_q <= '0;
         cnt_q   <= '0;
      end else begin
         presc_q <= tick ? '0 : presc_q + 1'b1;
         if (tick) cnt_q <= cnt_q + 1'b1;
      end
   end

   always_comb begin
      case (speed_sel)
         2'b01:   preset = PWM_W'(SPD_LO);
         2'b10:   preset = PWM_W'(SPD_MID);
         2'b11:   preset = PWM_W'(SPD_HI);
         default: preset = '0;
      endcase
      dir_a_d = DIR_OFF;
      dir_b_d = DIR_OFF;
      if (StepEnable) begin
         case ({iS1, iS2})
            2'b00:   begin dir_a_d = DIR_FWD; dir_b_d = DIR_FWD; end
            2'b01:   dir_a_d = DIR_FWD;
            2'b10:   dir_b_d = DIR_FWD;
            default: ;
         endcase
      end else begin
         case ({up, down, left, right})
            4'b1000: begin dir_a_d = DIR_FWD; dir_b_d = DIR_FWD; end
            4'b1001: dir_a_d = DIR_FWD;
            4'b1010: dir_b_d = DIR_FWD;
            4'b0100: begin dir_a_d = DIR_REV; dir_b_d = DIR_REV; end
            4'b0101: dir_a_d = DIR_REV;
            4'b0110: dir_b_d = DIR_REV;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         dir_a_q <= DIR_OFF;
         dir_b_q <= DIR_OFF;
         tgt_a_q <= '0;
         tgt_b_q <= '0;
      end else begin
         dir_a_q <= dir_a_d;
         dir_b_q <= dir_b_d;
         tgt_a_q <= (dir_a_d == DIR_OFF) ? '0 : preset;
         tgt_b_q <= (dir_b_d == DIR_OFF) ? '0 : preset;
      end
   end

   motor_channel #(
      .PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)
   ) u_chan_a (
      .clk(CLK), .rst(rst), .pb(pb), .cnt(cnt_q), .cmd_dir(dir_a_q), .target(tgt_a_q),
      .pin_fwd(IN2), .pin_rev(IN1), .duty(duty_a)
   );

   motor_channel #(
      .PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)
   ) u_chan_b (
      .clk(CLK), .rst(rst), .pb(pb), .cnt(cnt_q), .cmd_dir(dir_b_q), .target(tgt_b_q),
      .pin_fwd(IN3), .pin_rev(IN4), .duty(duty_b)
   );

endmodule
